// File: rtl/brick_map_ctrl_if.sv
// Bus between the brick map controller and the level ROM, the tank block and the HUD.
interface brick_map_ctrl_if;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned COLS   = 40;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned DIR_W  = 4;
  localparam int unsigned CNT_W  = 11;

  logic              level_reload;
  logic [ADDR_W-1:0] level_rom_addr;
  logic [COLS-1:0]   level_rom_data;
  logic              bullet_active;
  logic [POS_W-1:0]  bullet_x;
  logic [POS_W-1:0]  bullet_y;
  logic [DIR_W-1:0]  bullet_dir;
  logic [COLS-1:0]   brick_map [0:ROWS-1];
  logic              map_ready;
  logic              brick_hit;
  logic [CNT_W-1:0]  bricks_remaining;

  // Controller side
  modport slave (
    input  level_reload, level_rom_data,
    input  bullet_active, bullet_x, bullet_y, bullet_dir,
    output level_rom_addr, brick_map, map_ready, brick_hit, bricks_remaining
  );

  // Environment side (ROM, tank block, HUD)
  modport master (
    output level_reload, level_rom_data,
    output bullet_active, bullet_x, bullet_y, bullet_dir,
    input  level_rom_addr, brick_map, map_ready, brick_hit, bricks_remaining
  );
endinterface

// File: rtl/brick_map_ctrl.sv
// Brick map owner: loads a level from the ROM, clears bricks hit by the player bullet.
module brick_map_ctrl #(
  parameter int unsigned ROWS        = 30,
  parameter int unsigned COLS        = 40,
  parameter int unsigned BULLET_STEP = 4,
  parameter int unsigned BULLET_SIZE = 8
) (
  input logic             frame_clk,
  input logic             Reset,
  brick_map_ctrl_if.slave bus
);

  localparam int unsigned LOAD_W = 5;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned CELL_W = 7;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned HIT_W  = 3;
  localparam int unsigned ROW_IW = $clog2(ROWS);
  localparam int unsigned COL_IW = $clog2(COLS);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
  logic [COLS-1:0]   brick_map_q [0:ROWS-1];
  logic [COLS-1:0]   brick_map_d [0:ROWS-1];
  logic              map_ready_q, map_ready_d;
  logic              brick_hit_q, brick_hit_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;

  logic [POS_W-1:0]  dx, dy, px, py;
  logic [POS_W:0]    px_end, py_end;
  logic [CELL_W-1:0] r0, r1, c0, c1;
  logic              r0_v, r1_v, c0_v, c1_v, r1_dup;
  logic [COL_IW-1:0] c0_bit, c1_bit;
  logic [COLS-1:0]   col_mask, row0, row1;
  logic [HIT_W-1:0]  hit_cnt;

  // Probe footprint one bullet step ahead; far edges kept one bit wider so they never wrap into range
  always_comb begin
    dx = '0;
    dy = '0;
    case (bus.bullet_dir)
      4'b0001: dy = POS_W'(0) - POS_W'(BULLET_STEP);
      4'b0010: dy = POS_W'(BULLET_STEP);
      4'b0100: dx = POS_W'(0) - POS_W'(BULLET_STEP);
      4'b1000: dx = POS_W'(BULLET_STEP);
      default: ;
    endcase
    px     = bus.bullet_x + dx;
    py     = bus.bullet_y + dy;
    px_end = {1'b0, px} + (POS_W+1)'(BULLET_SIZE - 1);
    py_end = {1'b0, py} + (POS_W+1)'(BULLET_SIZE - 1);
    c0     = {1'b0, px[POS_W-1:4]};
    c1     = px_end[POS_W:4];
    r0     = {1'b0, py[POS_W-1:4]};
    r1     = py_end[POS_W:4];
    c0_v   = c0 < CELL_W'(COLS);
    c1_v   = c1 < CELL_W'(COLS);
    r0_v   = r0 < CELL_W'(ROWS);
    r1_v   = r1 < CELL_W'(ROWS);
    r1_dup = r1 == r0;
    c0_bit = COL_IW'(COLS - 1) - c0[COL_IW-1:0];
    c1_bit = COL_IW'(COLS - 1) - c1[COL_IW-1:0];
    col_mask = '0;
    if (c0_v) col_mask[c0_bit] = 1'b1;
    if (c1_v) col_mask[c1_bit] = 1'b1;
    row0 = r0_v ? brick_map_q[r0[ROW_IW-1:0]] : '0;
    row1 = (r1_v && !r1_dup) ? brick_map_q[r1[ROW_IW-1:0]] : '0;
    hit_cnt = HIT_W'($countones(row0 & col_mask)) + HIT_W'($countones(row1 & col_mask));
  end

  // Next-state: reload clears and restarts, LOAD streams ROM rows, RUN clears struck bricks
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    brick_map_d = brick_map_q;
    map_ready_d = map_ready_q;
    brick_hit_d = 1'b0;
    remaining_d = remaining_q;
    if (bus.level_reload) begin
      state_d     = S_LOAD;
      load_cnt_d  = '0;
      map_ready_d = 1'b0;
      remaining_d = '0;
      for (int r = 0; r < ROWS; r++) brick_map_d[r] = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          load_cnt_d = load_cnt_q + LOAD_W'(1);
          if (load_cnt_q != '0) begin
            brick_map_d[load_cnt_q - LOAD_W'(1)] = bus.level_rom_data;
            remaining_d = remaining_q + CNT_W'($countones(bus.level_rom_data));
          end
          if (load_cnt_q == LOAD_W'(ROWS)) begin
            state_d     = S_RUN;
            map_ready_d = 1'b1;
          end
        end
        default: begin
          if (bus.bullet_active) begin
            for (int r = 0; r < ROWS; r++) begin
              if ((r0_v && r0 == CELL_W'(r)) || (r1_v && r1 == CELL_W'(r)))
                brick_map_d[r] = brick_map_q[r] & ~col_mask;
            end
            remaining_d = (remaining_q > CNT_W'(hit_cnt)) ? remaining_q - CNT_W'(hit_cnt) : '0;
            brick_hit_d = hit_cnt != '0;
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      map_ready_q <= 1'b0;
      brick_hit_q <= 1'b0;
      remaining_q <= '0;
      for (int r = 0; r < ROWS; r++) brick_map_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      map_ready_q <= map_ready_d;
      brick_hit_q <= brick_hit_d;
      remaining_q <= remaining_d;
      for (int r = 0; r < ROWS; r++) brick_map_q[r] <= brick_map_d[r];
    end
  end

  assign bus.level_rom_addr   = (state_q == S_LOAD) ? load_cnt_q : '0;
  assign bus.brick_map        = brick_map_q;
  assign bus.map_ready        = map_ready_q;
  assign bus.brick_hit        = brick_hit_q;
  assign bus.bricks_remaining = remaining_q;

endmodule

// File: doc/brick_map_ctrl.md
Name: brick_map_ctrl

Overview:
Owns the 30x40 brick map of 16x16-pixel cells that the tank block reads for movement and bullet collision.
- Loads a level layout row by row from an external synchronous level ROM.
- Destroys bricks struck by the player bullet, using the same next-position footprint the tank block uses to retire the bullet.
- Reports the remaining-brick count and a per-frame hit pulse to the score/HUD logic.

Parameters:
ROWS, 30, number of map rows (480/16)
COLS, 40, number of map columns (640/16)
BULLET_STEP, 4, bullet pixels moved per frame_clk
BULLET_SIZE, 8, bullet box edge in pixels

Ports:
frame_clk  input  1  the single clock; all state changes on its rising edge
Reset  input  1  synchronous, active-high reset
level_reload  input  1  one-cycle pulse; reloads the map from the ROM
level_rom_addr  output  5  ROM row address
level_rom_data  input  40  ROM row data; valid one cycle after the address is presented
bullet_active  input  1  player bullet in flight
bullet_x  input  10  bullet left edge, pixels
bullet_y  input  10  bullet top edge, pixels
bullet_dir  input  4  one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right
brick_map  output  40 x [0:29]  map; row r, column c stored at brick_map[r][39-c]
map_ready  output  1  high in RUN
brick_hit  output  1  one-cycle pulse; at least one brick was cleared this edge
bricks_remaining  output  11  count of set map bits (maximum 1200)

Behaviour:
- States: LOAD and RUN.
- Reset:
  - state LOAD; load_cnt 0.
  - All brick_map rows 0; bricks_remaining 0; map_ready 0; brick_hit 0.
- LOAD:
  - level_rom_addr = load_cnt[4:0], driven combinationally from the register.
  - Every edge: load_cnt increments.
  - When load_cnt >= 1: row[load_cnt-1] <= level_rom_data, and bricks_remaining += popcount(level_rom_data).
  - The edge with load_cnt == 30 writes row 29 and moves to RUN.
  - LOAD lasts exactly 31 edges after Reset deasserts.
  - Bullet inputs are ignored; brick_hit stays 0.
- Entry into LOAD from level_reload (in any state, including LOAD itself):
  - Clears all rows, bricks_remaining, load_cnt and map_ready on that edge.
  - Restarts the sequence above.
- RUN:
  - level_rom_addr = 0.
  - Each edge, when bullet_active = 1, compute the probe position:
    - px = bullet_x + dx, py = bullet_y + dy, 10-bit modulo.
    - dx/dy = ±BULLET_STEP by bullet_dir; both 0 if bullet_dir is not one-hot.
  - Footprint cells:
    - rows r0 = py>>4, r1 = (py+7)>>4.
    - columns c0 = px>>4, c1 = (px+7)>>4.
    - Up to 4 distinct (r,c) pairs; duplicates count once.
  - Any cell with r > 29 or c > 39 (including negative positions that wrap to large values) is ignored, never aliased.
  - Every in-range footprint cell whose bit is 1 is cleared on this edge.
  - bricks_remaining decrements by the number of distinct bits cleared (0–4); it never underflows.
  - brick_hit <= 1 if that number is > 0, else 0.
- Timing: the map clears on the same edge the tank block deactivates the bullet, so there is no double hit on the following frame.
- bullet_active = 0: no map change; brick_hit <= 0.
- Reset has priority over level_reload, which has priority over hit processing.
- brick_map is registered; read paths into the tank block are combinational from these registers.

Test Plan:
- Reset: hold Reset 2 cycles, ROM returns row r = 40'h00000_00001 when r is even, else 0 → after exactly 31 edges map_ready = 1, bricks_remaining = 15, row 0 bit 0 = 1 (column 39), row 1 = 0.
- Single hit: map holds only cell (10,20) set (bit 19), bricks_remaining = 1; bullet_active = 1, x = 324, y = 172, dir = 0001 → one edge later bit 19 = 0, brick_hit = 1 for exactly 1 cycle, bricks_remaining = 0.
- Straddle: cells (10,19) and (10,20) set, bricks_remaining = 2; x = 316, y = 172, dir = 0001 → both bits cleared on one edge, bricks_remaining = 0, single brick_hit pulse.
- Edge wrap: bullet x = 2, y = 200, dir = 0100 (probe px = 1022) → no map change, brick_hit = 0, no out-of-range index.
- Reload mid-RUN with a hit on the same edge: level_reload = 1 and a valid hit → map cleared, state LOAD, brick_hit = 0, bricks_remaining restarts from 0; Reset asserted at load_cnt = 12 → restarts with load_cnt 0.
- Idle bullet and bad dir: bullet_active = 0 over a set cell → no change; bullet_active = 1, dir = 0011 over a set cell → probe equals (x,y), and that cell is cleared.
